// File: rtl/atm_audio_pkg.sv
// Shared types for the audio output arbiter: FSM states, grant codes and a
// small helper used to size the shared counters.
package atm_audio_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGap,
        StPlayFront,
        StPlayAfter,
        StBeep
    } arb_state_e;

    // Encoding of the grant output: who currently owns the amplifier.
    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_FRONT = 2'd1,
        GNT_AFTER = 2'd2,
        GNT_BEEP  = 2'd3
    } grant_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/audio_arbiter_if.sv
// Bundle of the arbiter's source requests, player audio and amplifier pins.
// The master side (players/keypad/board) drives requests and audio; the slave
// side (the arbiter) drives the pmod pins and status.
interface audio_arbiter_if;

    logic       beep_req;
    logic       music_front_on;
    logic       music_after_on;
    logic       front_pwm;
    logic       front_gain;
    logic       after_pwm;
    logic       after_gain;
    logic       pmod_1;
    logic       pmod_2;
    logic       pmod_4;
    logic [1:0] grant;
    logic       busy;

    modport master (
        output beep_req,
        output music_front_on,
        output music_after_on,
        output front_pwm,
        output front_gain,
        output after_pwm,
        output after_gain,
        input  pmod_1,
        input  pmod_2,
        input  pmod_4,
        input  grant,
        input  busy
    );

    modport slave (
        input  beep_req,
        input  music_front_on,
        input  music_after_on,
        input  front_pwm,
        input  front_gain,
        input  after_pwm,
        input  after_gain,
        output pmod_1,
        output pmod_2,
        output pmod_4,
        output grant,
        output busy
    );

endinterface

// File: rtl/tone_gen.sv
// Square-wave divider for the key-click beep. While enabled the output
// starts low and flips every half_i cycles; while disabled it is held low
// with its counter cleared so every beep starts from the same phase.
module tone_gen #(
    parameter int unsigned CntW = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic [CntW-1:0] half_i,
    output logic            tone_o
);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tone_q, tone_d;

    // Count out one half-period, then flip the tone.
    always_comb begin
        cnt_d  = cnt_q;
        tone_d = tone_q;
        if (!en_i) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if ((cnt_q + CntW'(1)) >= half_i) begin
            cnt_d  = '0;
            tone_d = ~tone_q;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Divider state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

    assign tone_o = tone_q;

endmodule

// File: rtl/audio_arbiter.sv
// Arbitrates the single PWM amplifier between the key-click beep and two
// music players (priority beep > after > front). Every change of owner passes
// through a muted GAP so the amplifier never sees two sources back to back.
// All pins are registered: they reflect the state and inputs of the
// previous cycle.
module audio_arbiter
    import atm_audio_pkg::*;
#(
    parameter int unsigned GAP_CYCLES  = 100000,
    parameter int unsigned BEEP_CYCLES = 10000000,
    parameter int unsigned BEEP_HALF   = 50000,
    parameter int unsigned MIN_HOLD    = 1000000
) (
    input logic            clk,
    input logic            reset,
    audio_arbiter_if.slave aud_io
);

    localparam int unsigned CntMax =
        max_u(max_u(GAP_CYCLES, BEEP_CYCLES), max_u(BEEP_HALF, MIN_HOLD));
    localparam int unsigned CntW = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);
    localparam logic [CntW-1:0] BeepLast = CntW'(BEEP_CYCLES - 1);
    localparam logic [CntW-1:0] HoldMax  = CntW'(MIN_HOLD);
    localparam logic [CntW-1:0] HalfCnt  = CntW'(BEEP_HALF);

    arb_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            beep_pend_q, beep_pend_d;
    logic            pend_now;
    logic            tone;

    logic            pmod_1_q, pmod_1_d;
    logic            pmod_2_q, pmod_2_d;
    logic            pmod_4_q, pmod_4_d;
    grant_e          grant_q, grant_d;
    logic            busy_q, busy_d;

    tone_gen #(
        .CntW (CntW)
    ) u_tone_gen (
        .clk_i  (clk),
        .rst_i  (reset),
        .en_i   (state_q == StBeep),
        .half_i (HalfCnt),
        .tone_o (tone)
    );

    // Next state: a beep request counts as pending in the cycle it arrives.
    always_comb begin
        state_d  = state_q;
        pend_now = beep_pend_q | aud_io.beep_req;
        unique case (state_q)
            StIdle: begin
                if (pend_now || aud_io.music_front_on || aud_io.music_after_on) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    if (pend_now) begin
                        state_d = StBeep;
                    end else if (aud_io.music_after_on) begin
                        state_d = StPlayAfter;
                    end else if (aud_io.music_front_on) begin
                        state_d = StPlayFront;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StPlayFront: begin
                // After may only take over once front has played its minimum hold.
                if (pend_now || !aud_io.music_front_on ||
                    (aud_io.music_after_on && (cnt_q == HoldMax))) begin
                    state_d = StGap;
                end
            end
            StPlayAfter: begin
                if (pend_now || !aud_io.music_after_on) begin
                    state_d = StGap;
                end
            end
            StBeep: begin
                // A fresh keypress in the last cycle extends the beep instead.
                if ((cnt_q == BeepLast) && !aud_io.beep_req) begin
                    state_d = StGap;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Shared counter: gap length, play hold time or beep duration; zero on entry.
    always_comb begin
        cnt_d = '0;
        if (state_d == state_q) begin
            unique case (state_q)
                StGap:       cnt_d = cnt_q + CntW'(1);
                StPlayFront,
                StPlayAfter: cnt_d = (cnt_q == HoldMax) ? cnt_q : cnt_q + CntW'(1);
                StBeep:      cnt_d = aud_io.beep_req ? '0 : cnt_q + CntW'(1);
                default:     cnt_d = '0;
            endcase
        end
    end

    // Beep pending flag: latched outside BEEP, consumed on entry to BEEP.
    always_comb begin
        beep_pend_d = beep_pend_q;
        if ((state_d == StBeep) && (state_q != StBeep)) begin
            beep_pend_d = 1'b0;
        end else if (aud_io.beep_req && (state_q != StBeep)) begin
            beep_pend_d = 1'b1;
        end
    end

    // Pin values for the current owner; muted with the amplifier off otherwise.
    always_comb begin
        pmod_1_d = 1'b0;
        pmod_2_d = 1'b0;
        pmod_4_d = 1'b0;
        grant_d  = GNT_NONE;
        busy_d   = (state_q != StIdle);
        unique case (state_q)
            StPlayFront: begin
                pmod_1_d = aud_io.front_pwm;
                pmod_2_d = aud_io.front_gain;
                pmod_4_d = 1'b1;
                grant_d  = GNT_FRONT;
            end
            StPlayAfter: begin
                pmod_1_d = aud_io.after_pwm;
                pmod_2_d = aud_io.after_gain;
                pmod_4_d = 1'b1;
                grant_d  = GNT_AFTER;
            end
            StBeep: begin
                pmod_1_d = tone;
                pmod_2_d = 1'b1;
                pmod_4_d = 1'b1;
                grant_d  = GNT_BEEP;
            end
            default: ;
        endcase
    end

    // Control state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            beep_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            beep_pend_q <= beep_pend_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pmod_1_q <= 1'b0;
            pmod_2_q <= 1'b0;
            pmod_4_q <= 1'b0;
            grant_q  <= GNT_NONE;
            busy_q   <= 1'b0;
        end else begin
            pmod_1_q <= pmod_1_d;
            pmod_2_q <= pmod_2_d;
            pmod_4_q <= pmod_4_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
        end
    end

    assign aud_io.pmod_1 = pmod_1_q;
    assign aud_io.pmod_2 = pmod_2_q;
    assign aud_io.pmod_4 = pmod_4_q;
    assign aud_io.grant  = grant_q;
    assign aud_io.busy   = busy_q;

endmodule

// File: doc/audio_arbiter.md
AUDIO_ARBITER -- requirements
Module: audio_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, 100000, silent muted cycles inserted at every source switch (1 ms at 100 MHz).
REQ-002 Parameter BEEP_CYCLES, 10000000, key-click beep duration in cycles (100 ms).
REQ-003 Parameter BEEP_HALF, 50000, beep tone half-period in cycles (1 kHz tone).
REQ-004 Parameter MIN_HOLD, 1000000, minimum cycles a music source plays before a higher-priority music source may preempt it.
REQ-005 clk  input  1  system clock, 100 MHz.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 beep_req  input  1  single-cycle keypress pulse.
REQ-008 music_front_on, music_after_on  input  1 each  level requests from the two music players.
REQ-009 front_pwm, front_gain, after_pwm, after_gain  input  1 each  audio and gain from the players.
REQ-010 pmod_1  output  1  PWM audio to the amplifier.
REQ-011 pmod_2  output  1  gain select.
REQ-012 pmod_4  output  1  amplifier enable; 1 = on.
REQ-013 grant  output  2  current owner: 0 none, 1 front, 2 after, 3 beep.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The block SHALL implement states IDLE, GAP, PLAY_FRONT, PLAY_AFTER and BEEP.
REQ-016 Priority SHALL be beep > after > front.
REQ-017 beep_req SHALL set a beep_pend flag; the flag SHALL clear on entry to BEEP.
REQ-018 IDLE SHALL go to GAP when beep_pend or either music request is set.
REQ-019 GAP SHALL count GAP_CYCLES cycles with pmod_1=0, pmod_2=0, pmod_4=0 and grant=0.
REQ-020 At the end of GAP, the block SHALL enter the highest-priority request pending in that cycle, or IDLE if none is pending.
REQ-021 PLAY_FRONT and PLAY_AFTER SHALL pass the owner's pwm/gain to pmod_1/pmod_2 with pmod_4=1.
REQ-022 Each play state SHALL run a hold counter that saturates at MIN_HOLD.
REQ-023 A play state SHALL go to GAP when its own request drops.
REQ-024 A play state SHALL go to GAP on beep_pend immediately, regardless of hold.
REQ-025 PLAY_FRONT SHALL go to GAP when music_after_on is high and the hold counter has reached MIN_HOLD.
REQ-026 PLAY_AFTER SHALL never be preempted by front.
REQ-027 BEEP SHALL output a square wave on pmod_1 that toggles every BEEP_HALF cycles and starts low, with pmod_2=1, pmod_4=1 and grant=3.
REQ-028 BEEP SHALL last BEEP_CYCLES cycles and then go to GAP.
REQ-029 A beep_req arriving during BEEP, including in its final cycle, SHALL restart the duration count with no state change and no GAP.
REQ-030 A beep_req arriving during GAP SHALL be resolved at the end of GAP.
REQ-031 All outputs SHALL be registered, giving 1-cycle latency from state/inputs to pmod pins.
REQ-032 Counters SHALL be $clog2(max(param)+1) bits wide and SHALL reload to zero on every state entry.

Reset
REQ-033 While reset is high, the block SHALL hold state=IDLE, all counters=0, beep_pend=0, pmod_1=0, pmod_2=0, pmod_4=0, grant=0 and busy=0.
REQ-034 Reset asserted mid-beep or mid-gap SHALL abort it with no residual pending beep.
REQ-035 Reset SHALL be deasserted synchronously to clk by the top-level.

Structure
REQ-036 The state enum and grant codes (GNT_NONE/FRONT/AFTER/BEEP) SHALL reside in shared package atm_audio_pkg.
REQ-037 The square-wave divider SHALL be a sub-module, tone_gen (enable, half-period count, output bit).
REQ-038 The block SHALL be instantiated in the top-level in place of the direct pmod muxing.

Verification (GAP=4, BEEP=20, HALF=2, HOLD=10)
REQ-039 Test: music_front_on=1 from IDLE -> grant=0 for 4 cycles of GAP, then grant=1; pmod_1 follows front_pwm 1 cycle later.
REQ-040 Test: front playing 3 cycles, then beep_req -> GAP (4 cycles) -> BEEP; pmod_1 toggles every 2 cycles for 20 cycles -> GAP -> grant=1.
REQ-041 Test: front playing, music_after_on rises at hold=5 -> switch deferred until hold=10, then GAP -> grant=2; front request during after play -> no switch.
REQ-042 Test: beep_req in BEEP's last cycle -> BEEP extends a further 20 cycles with no GAP in between.
REQ-043 Test: both music requests drop during GAP -> IDLE, busy=0, pmod_4=0.
REQ-044 Test: reset pulse mid-BEEP -> all outputs 0 next cycle; after release, no beep replays.
